// File: rtl/shift_pkg.sv
// shift_pkg: shared types and constants for the shift arbiter slice.
//   shift_op_e        - requester opcode (SLL/SRL/SRA/ILLEGAL)
//   shift_arb_state_e - output-register occupancy (EMPTY/FULL)
//   shift_req_t       - operands of the winning requester
//   shift_rsp_t       - shifter result
package shift_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    OP_SLL     = 2'b00,
    OP_SRL     = 2'b01,
    OP_SRA     = 2'b10,
    OP_ILLEGAL = 2'b11
  } shift_op_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } shift_arb_state_e;

  typedef struct packed {
    shift_op_e            op;
    logic [XLEN-1:0]      rs1;
    logic [SHAMT_W-1:0]   shamt;
  } shift_req_t;

  typedef struct packed {
    logic [XLEN-1:0] rd;
    logic            err;
  } shift_rsp_t;

endpackage

// File: rtl/shift_right_arithmetic.sv
// shift_right_arithmetic: combinational arithmetic right shift (sign fill).
//   data_i  - value to shift
//   shamt_i - shift amount
//   data_o  - data_i >>> shamt_i
module shift_right_arithmetic #(
  parameter int W  = 32,
  parameter int SW = 5
) (
  input  logic [W-1:0]  data_i,
  input  logic [SW-1:0] shamt_i,
  output logic [W-1:0]  data_o
);

  assign data_o = $unsigned($signed(data_i) >>> shamt_i);

endmodule

// File: rtl/shift_unit.sv
// shift_unit: combinational SLL/SRL/SRA selector.
//   req_i - opcode, value and 5-bit shift amount
//   rsp_o - result; illegal opcode yields rd = 0, err = 1
module shift_unit
  import shift_pkg::*;
(
  input  shift_req_t req_i,
  output shift_rsp_t rsp_o
);

  logic [XLEN-1:0] sra_res;

  shift_right_arithmetic #(
    .W  (XLEN),
    .SW (SHAMT_W)
  ) u_sra (
    .data_i  (req_i.rs1),
    .shamt_i (req_i.shamt),
    .data_o  (sra_res)
  );

  always_comb begin
    rsp_o = '0;
    case (req_i.op)
      OP_SLL:  rsp_o.rd = req_i.rs1 << req_i.shamt;
      OP_SRL:  rsp_o.rd = req_i.rs1 >> req_i.shamt;
      OP_SRA:  rsp_o.rd = sra_res;
      default: rsp_o.err = 1'b1;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin arbiter sharing one shift_unit between NUM_REQ
// requesters, with a one-entry registered result stage.
//   clk_i, rst_ni          - clock, async active-low reset
//   req_valid_i/ready_o    - per-requester handshake (ready is the one-hot grant)
//   req_op_i/rs1_i/rs2_i   - per-requester opcode and operands (rs2[4:0] used)
//   rsp_valid_o/ready_i    - result handshake
//   rsp_id_o/rd_o/err_o    - owner index, result, illegal-op flag
// Optional: define SHIFT_ARB_PERF_EN to add perf_grant_cnt_o and
// perf_conflict_cnt_o (32-bit wrapping counters).
module shift_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  input  logic [NUM_REQ-1:0][1:0]           req_op_i,
  input  logic [NUM_REQ-1:0][XLEN-1:0]      req_rs1_i,
  input  logic [NUM_REQ-1:0][XLEN-1:0]      req_rs2_i,
  output logic                              rsp_valid_o,
  input  logic                              rsp_ready_i,
  output logic [ID_W-1:0]                   rsp_id_o,
  output logic [XLEN-1:0]                   rsp_rd_o,
  output logic                              rsp_err_o
`ifdef SHIFT_ARB_PERF_EN
  ,
  output logic [31:0]                       perf_grant_cnt_o,
  output logic [31:0]                       perf_conflict_cnt_o
`endif
);

  import shift_pkg::*;

  shift_arb_state_e state_q, state_d;
  logic [ID_W-1:0]  prio_q, prio_d;
  logic [XLEN-1:0]  rd_q, rd_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             err_q, err_d;

  logic             gnt_ok;
  logic             found;
  logic [ID_W-1:0]  win;
  int               rr_idx;
  shift_req_t       sel_req;
  shift_rsp_t       sel_rsp;

  // A held result blocks new grants unless it is drained this same cycle.
  assign gnt_ok = (state_q == ST_EMPTY) || rsp_ready_i;

  // Round-robin search: first valid requester at or after prio_q.
  always_comb begin
    found  = 1'b0;
    win    = '0;
    rr_idx = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rr_idx = int'(prio_q) + i;
      if (rr_idx >= NUM_REQ) rr_idx = rr_idx - NUM_REQ;
      if (!found && req_valid_i[rr_idx]) begin
        found = 1'b1;
        win   = ID_W'(rr_idx);
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (gnt_ok && found) req_ready_o[win] = 1'b1;
  end

  always_comb begin
    sel_req.op    = shift_op_e'(req_op_i[win]);
    sel_req.rs1   = req_rs1_i[win];
    sel_req.shamt = req_rs2_i[win][SHAMT_W-1:0];
  end

  shift_unit u_shift (
    .req_i (sel_req),
    .rsp_o (sel_rsp)
  );

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    rd_d    = rd_q;
    id_d    = id_q;
    err_d   = err_q;
    if (gnt_ok && found) begin
      state_d = ST_FULL;
      prio_d  = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      rd_d    = sel_rsp.rd;
      id_d    = win;
      err_d   = sel_rsp.err;
    end else if (state_q == ST_FULL && rsp_ready_i) begin
      state_d = ST_EMPTY;
    end
  end

`ifdef SHIFT_ARB_PERF_EN
  logic [31:0] perf_grant_q, perf_grant_d;
  logic [31:0] perf_conf_q, perf_conf_d;
  int          nvalid;

  always_comb begin
    nvalid = 0;
    for (int i = 0; i < NUM_REQ; i++) nvalid = nvalid + int'(req_valid_i[i]);
    perf_grant_d = perf_grant_q + ((gnt_ok && found) ? 32'd1 : 32'd0);
    // Only one grant can ever be issued, so two valid means a conflict.
    perf_conf_d  = perf_conf_q + ((nvalid >= 2) ? 32'd1 : 32'd0);
  end

  assign perf_grant_cnt_o    = perf_grant_q;
  assign perf_conflict_cnt_o = perf_conf_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_EMPTY;
      prio_q       <= '0;
      rd_q         <= '0;
      id_q         <= '0;
      err_q        <= 1'b0;
`ifdef SHIFT_ARB_PERF_EN
      perf_grant_q <= '0;
      perf_conf_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      rd_q         <= rd_d;
      id_q         <= id_d;
      err_q        <= err_d;
`ifdef SHIFT_ARB_PERF_EN
      perf_grant_q <= perf_grant_d;
      perf_conf_q  <= perf_conf_d;
`endif
    end
  end

  assign rsp_valid_o = (state_q == ST_FULL);
  assign rsp_rd_o    = rd_q;
  assign rsp_id_o    = id_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_shift_arbiter.sv
module tb_shift_arbiter;

  localparam int N    = 3;
  localparam int IDW  = $clog2(N);

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic [N-1:0]          req_valid_i;
  logic [N-1:0]          req_ready_o;
  logic [N-1:0][1:0]     req_op_i;
  logic [N-1:0][31:0]    req_rs1_i;
  logic [N-1:0][31:0]    req_rs2_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [IDW-1:0]        rsp_id_o;
  logic [31:0]           rsp_rd_o;
  logic                  rsp_err_o;
`ifdef SHIFT_ARB_PERF_EN
  logic [31:0]           perf_grant_cnt_o;
  logic [31:0]           perf_conflict_cnt_o;
`endif

  shift_arbiter #(.NUM_REQ(N), .XLEN(32)) dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .req_valid_i         (req_valid_i),
    .req_ready_o         (req_ready_o),
    .req_op_i            (req_op_i),
    .req_rs1_i           (req_rs1_i),
    .req_rs2_i           (req_rs2_i),
    .rsp_valid_o         (rsp_valid_o),
    .rsp_ready_i         (rsp_ready_i),
    .rsp_id_o            (rsp_id_o),
    .rsp_rd_o            (rsp_rd_o),
    .rsp_err_o           (rsp_err_o)
`ifdef SHIFT_ARB_PERF_EN
    ,
    .perf_grant_cnt_o    (perf_grant_cnt_o),
    .perf_conflict_cnt_o (perf_conflict_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference shift computed from the opcode rules; SRA built from SRL by
  // complementing, so it does not share the >>> operator with the design.
  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      2'd0:    return a << sh;
      2'd1:    return a >> sh;
      2'd2:    return a[31] ? ~((~a) >> sh) : (a >> sh);
      default: return 32'd0;
    endcase
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  bit          m_full = 0;
  int          m_prio = 0;
  logic [31:0] m_rd   = 0;
  int          m_id   = 0;
  bit          m_err  = 0;
  logic [31:0] m_gcnt = 0;
  logic [31:0] m_ccnt = 0;

  always @(negedge clk_i) begin
    logic [N-1:0] exp_gnt;
    int w;
    int nv;
    if (!rst_ni) begin
      m_full = 0; m_prio = 0; m_gcnt = 0; m_ccnt = 0;
      chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      chk("rst_req_ready", 32'(req_ready_o), 32'd0);
      chk("rst_rsp_rd",    rsp_rd_o,         32'd0);
    end else begin
      exp_gnt = '0;
      w  = -1;
      nv = 0;
      for (int k = 0; k < N; k++) begin
        if (req_valid_i[k]) nv++;
        if (w < 0 && req_valid_i[(m_prio + k) % N]) w = (m_prio + k) % N;
      end
      if (!(m_full && !rsp_ready_i) && w >= 0) exp_gnt[w] = 1'b1;
      chk("req_ready", 32'(req_ready_o), 32'(exp_gnt));
      chk("rsp_valid", 32'(rsp_valid_o), 32'(m_full));
      if (m_full) begin
        chk("rsp_rd",  rsp_rd_o,         m_rd);
        chk("rsp_id",  32'(rsp_id_o),    32'(m_id));
        chk("rsp_err", 32'(rsp_err_o),   32'(m_err));
      end
`ifdef SHIFT_ARB_PERF_EN
      chk("perf_grant",    perf_grant_cnt_o,    m_gcnt);
      chk("perf_conflict", perf_conflict_cnt_o, m_ccnt);
`endif
      if (exp_gnt != '0) begin
        m_full = 1;
        m_rd   = ref_shift(req_op_i[w], req_rs1_i[w], req_rs2_i[w]);
        m_err  = (req_op_i[w] == 2'd3);
        m_id   = w;
        m_prio = (w + 1) % N;
        m_gcnt = m_gcnt + 1;
      end else if (m_full && rsp_ready_i) begin
        m_full = 0;
      end
      if (nv >= 2) m_ccnt = m_ccnt + 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_one(input int r, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_rd,
                        input logic exp_err, input string nm);
    logic [N-1:0] onehot;
    onehot = '0;
    onehot[r] = 1'b1;
    req_valid_i = onehot;
    req_op_i[r] = op; req_rs1_i[r] = a; req_rs2_i[r] = b;
    #1 chk({nm, "_grant"}, 32'(req_ready_o), 32'(onehot));
    tick();
    req_valid_i = '0;
    chk({nm, "_valid"}, 32'(rsp_valid_o), 32'd1);
    chk({nm, "_rd"},    rsp_rd_o,         exp_rd);
    chk({nm, "_id"},    32'(rsp_id_o),    32'(r));
    chk({nm, "_err"},   32'(rsp_err_o),   32'(exp_err));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] last_gnt;
    logic [N-1:0] exp_c;
    rst_ni = 1'b0;
    req_valid_i = '0; req_op_i = '0; req_rs1_i = '0; req_rs2_i = '0;
    rsp_ready_i = 1'b1;
    repeat (3) tick();
    rst_ni = 1'b1;

    // Idle after reset: everything stays zero and the pointer stays at 0.
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_valid", 32'(rsp_valid_o), 32'd0);
      chk("idle_ready", 32'(req_ready_o), 32'd0);
      chk("idle_rd",    rsp_rd_o,         32'd0);
      chk("idle_id",    32'(rsp_id_o) | 32'(rsp_err_o), 32'd0);
      chk("idle_prio",  32'(dut.prio_q),  32'd0);
    end

    do_one(0, 2'd2, 32'h8000_0000, 32'd4,  32'hF800_0000, 1'b0, "sra");
    do_one(1, 2'd1, 32'hFFFF_FFFF, 32'd33, 32'h7FFF_FFFF, 1'b0, "srl33");
    do_one(2, 2'd0, 32'h0000_0001, 32'd31, 32'h8000_0000, 1'b0, "sll31");
    do_one(0, 2'd3, 32'h1234_5678, 32'd3,  32'h0000_0000, 1'b1, "illegal");

    // Contention on requesters 0 and 1; pointer is at 1 after the last grant.
    req_valid_i = 3'b011;
    req_op_i[0] = 2'd0; req_rs1_i[0] = 32'h1; req_rs2_i[0] = 32'd1;
    req_op_i[1] = 2'd1; req_rs1_i[1] = 32'h80; req_rs2_i[1] = 32'd2;
    for (int k = 0; k < 4; k++) begin
      exp_c = (k % 2 == 0) ? 3'b010 : 3'b001;
      #1 chk("contend_grant", 32'(req_ready_o), 32'(exp_c));
      tick();
    end
    req_valid_i = '0;
    tick();

    // Back-pressure: hold a result for 5 cycles, then same-cycle refill.
    req_valid_i = 3'b001; req_op_i[0] = 2'd0; req_rs1_i[0] = 32'd3; req_rs2_i[0] = 32'd2;
    rsp_ready_i = 1'b0;
    #1 chk("bp_first_grant", 32'(req_ready_o), 32'b001);
    tick();
    req_rs1_i[0] = 32'd5;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_ready_low", 32'(req_ready_o), 32'd0);
      chk("bp_rd_hold",   rsp_rd_o,         32'd12);
      chk("bp_valid",     32'(rsp_valid_o), 32'd1);
      tick();
    end
    rsp_ready_i = 1'b1;
    #1 chk("bp_refill", 32'(req_ready_o), 32'b001);
    tick();
    chk("bp_refill_rd", rsp_rd_o, 32'd20);
    req_valid_i = '0;
    tick();

    // Randomised traffic, honouring the hold-until-granted rule.
    last_gnt = '0;
    for (int c = 0; c < 1000; c++) begin
      for (int r = 0; r < N; r++) begin
        if (!(req_valid_i[r] && !last_gnt[r])) begin
          req_valid_i[r] = ($urandom_range(0, 99) < 60);
          req_op_i[r]    = 2'($urandom_range(0, 3));
          case ($urandom_range(0, 3))
            0:       req_rs1_i[r] = 32'h8000_0000 | $urandom;
            1:       req_rs1_i[r] = 32'hFFFF_FFFF;
            default: req_rs1_i[r] = $urandom;
          endcase
          req_rs2_i[r] = $urandom;
        end
      end
      rsp_ready_i = ($urandom_range(0, 99) < 70);
      #1 last_gnt = req_ready_o;
      tick();
    end

    // Hold a result, then reset mid-transaction: nothing must survive.
    req_valid_i = 3'b111; rsp_ready_i = 1'b0;
    tick();
    chk("pre_rst_valid", 32'(rsp_valid_o), 32'd1);
    rst_ni = 1'b0;
    req_valid_i = '0;
    #1 chk("async_rst_valid", 32'(rsp_valid_o), 32'd0);
    repeat (2) tick();
    rst_ni = 1'b1;
    rsp_ready_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("post_rst_valid", 32'(rsp_valid_o), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Shares one combinational shift datapath (SLL/SRL/SRA, built around `shift_right_arithmetic`) between `NUM_REQ` requesters in the execute stage. Fair round-robin grant, a one-entry registered result stage and a valid/ready response handshake. Requesters are, for example, the integer ALU and the address-generation path. Each result is returned tagged with the granted requester's index.

## Interface
- `NUM_REQ`, default 2: number of requesters, 2..8
- `XLEN`, default 32: operand width, fixed at 32 (shift amount uses 5 bits)
- `clk_i` in 1: clock, rising edge
- `rst_ni` in 1: asynchronous, active-low reset
- `req_valid_i` in `NUM_REQ`: request present, per requester
- `req_ready_o` out `NUM_REQ`: one-hot grant, request accepted this cycle
- `req_op_i` in `NUM_REQ`×2: `shift_op_e` per requester; 00 SLL, 01 SRL, 10 SRA, 11 illegal
- `req_rs1_i` in `NUM_REQ`×`XLEN`: value to shift
- `req_rs2_i` in `NUM_REQ`×`XLEN`: shift amount; only bits [4:0] are used
- `rsp_valid_o` out 1: result valid
- `rsp_ready_i` in 1: consumer accepts result
- `rsp_id_o` out `$clog2(NUM_REQ)`: index of the requester that owns the result
- `rsp_rd_o` out `XLEN`: shifted result
- `rsp_err_o` out 1: result came from an illegal op

## Operation
- FSM has two states. `EMPTY` means the output register is free. `FULL` means the output register holds an unaccepted result.
- A grant is allowed when the state is `EMPTY`, or when it is `FULL` and `rsp_ready_i` = 1 (pass-through refill).
- When a grant is allowed and any `req_valid_i` is set:
  - Exactly one `req_ready_o` bit goes high, combinationally.
  - The shifter result, id and err are captured in the output register.
  - The state becomes or stays `FULL`.
- When the state is `FULL`, `rsp_ready_i` = 1 and no request is valid, the state goes to `EMPTY`.
- Round-robin: the search starts at pointer `prio_q`. After a grant, `prio_q` becomes (winner+1) mod `NUM_REQ`. `prio_q` does not change when there is no grant.
- `req_ready_o` must never be high for a requester whose `req_valid_i` is low.
- While the state is `FULL`, the output register and `rsp_*` are held stable until `rsp_ready_i` = 1.
- Shift results:
  - SLL returns rs1 << rs2[4:0].
  - SRL returns the logical right shift.
  - SRA returns the arithmetic right shift, with sign fill from rs1[31].
  - rs2 bits [31:5] are ignored, so rs2 = 33 behaves as a shift of 1.
- Illegal op 11: `rsp_rd_o` = 0 and `rsp_err_o` = 1. It still consumes a grant slot.
- A requester must hold its valid and operands stable until it sees `req_ready_o`. The arbiter relies on this and does not check it.

## Timing
- Reset values:
  - State `EMPTY`, `prio_q` = 0.
  - `rsp_valid_o` = 0, `rsp_rd_o` = 0, `rsp_id_o` = 0, `rsp_err_o` = 0.
  - `req_ready_o` = 0.
- Latency: a grant in cycle N gives `rsp_valid_o` = 1 from cycle N+1.
- Throughput: one result per cycle while `rsp_ready_i` is held at 1.
- Back-pressure: while `rsp_ready_i` = 0 and the state is `FULL`, all `req_ready_o` bits are 0.
- If reset is asserted mid-transaction, the held result is dropped and no response is produced for it. Reset takes effect immediately because it is asynchronous.
- There is no combinational path from `req_*` to `rsp_*`. There is a combinational path from `rsp_ready_i` to `req_ready_o`.

## Configuration
- `SHIFT_ARB_PERF_EN` defined:
  - Adds output `perf_grant_cnt_o` [31:0], which increments on every grant.
  - Adds output `perf_conflict_cnt_o` [31:0], which increments in each cycle where at least two requesters are valid and at most one is granted.
  - Both counters reset to 0 and wrap from 0xFFFF_FFFF to 0.
- `SHIFT_ARB_PERF_EN` undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Structure
- Package `shift_pkg` holds:
  - `shift_op_e` (SLL, SRL, SRA, ILLEGAL)
  - `XLEN` and `SHAMT_W` = 5
  - the FSM state enum `shift_arb_state_e`
- Sub-module `shift_unit` is the combinational SLL/SRL/SRA selector. It instantiates `shift_right_arithmetic` for SRA. The arbiter instantiates `shift_unit` once, on the muxed operands of the winner.

## Test plan
- Reset release with no requests: all outputs stay 0 for 10 cycles and `prio_q` stays 0.
- Single SRA: requester 0 sends SRA with rs1 = 0x8000_0000, rs2 = 4. Expect a grant in cycle N, then in N+1 `rsp_rd_o` = 0xF800_0000, `rsp_id_o` = 0 and `rsp_err_o` = 0.
- Contention with `NUM_REQ` = 2, both valid continuously and `rsp_ready_i` = 1. Expect:
  - grants alternate 0, 1, 0, 1;
  - with PERF_EN, the conflict count increments every cycle.
- Back-pressure: `rsp_ready_i` = 0 for 5 cycles with a result held. Expect `rsp_*` stable and `req_ready_o` = 0 throughout. When `rsp_ready_i` rises, the next grant happens in the same cycle.
- Width and illegal ops:
  - SRL with rs1 = 0xFFFF_FFFF, rs2 = 33 gives 0x7FFF_FFFF.
  - SLL with rs1 = 1, rs2 = 31 gives 0x8000_0000.
  - Op 11 gives `rsp_rd_o` = 0 and `rsp_err_o` = 1.
- Randomized: 1000 random ops, operands and ready patterns, checked against a reference model. Then assert `rst_ni` mid-stream and expect no stale `rsp_valid_o` after reset.
